pin_entry_comparator: RTL

//  Captures keypad digits one at a time and compares each one against a stored PIN.

---
 rtl/pin_entry_comparator_pkg.sv | 15 +
 rtl/pin_entry_comparator_entry_timer.sv | 40 ++++
 rtl/pin_entry_comparator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pin_entry_comparator_pkg.sv
// Shared definitions for the PIN entry path: state encoding and the digit
// geometry defaults also used by the keypad scanner and the unlock FSM.
package pin_entry_comparator_pkg;

  localparam int DIGITS_DEF      = 4;
  localparam int DIGIT_W_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/pin_entry_comparator_entry_timer.sv
// Inter-digit idle timer: counts cycles while enabled, clears on request and
// saturates at TIMEOUT_CYC-1, where it flags expiry.
module pin_entry_comparator_entry_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise step up until the saturation point.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/pin_entry_comparator.sv
// Keypad PIN comparator: collects DIGITS key codes, compares each against the
// stored PIN on the fly and reports one registered match result per entry.
// Also handles PIN reprogramming (IDLE only) and the inter-digit timeout.
module pin_entry_comparator
  import pin_entry_comparator_pkg::*;
#(
  parameter int                        DIGITS      = DIGITS_DEF,
  parameter int                        DIGIT_W     = DIGIT_W_DEF,
  parameter int                        TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PIN = 16'h1234
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          key_clear,
  input  logic                          pin_load,
  input  logic [DIGITS*DIGIT_W-1:0]     pin_data,
  output logic                          equal,
  output logic                          entry_done,
  output logic                          entry_busy,
  output logic                          timeout,
  output logic                          pin_load_err,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt
);

  localparam int                CNT_W    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  state_e                      state_q, state_d;
  logic [DIGITS*DIGIT_W-1:0]   pin_q, pin_d;
  logic                        match_q, match_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        equal_q, equal_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        timeout_q, timeout_d;
  logic                        err_q, err_d;

  logic [DIGIT_W-1:0]          cur_digit;
  logic                        key_hit;
  logic                        timer_clr;
  logic                        timer_en;
  logic                        timer_expired;

  // The timer only runs inside an entry and restarts on every key or abort.
  assign timer_clr = (state_q != ST_COLLECT) || key_valid || key_clear;
  assign timer_en  = (state_q == ST_COLLECT);

  pin_entry_comparator_entry_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_entry_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Select the PIN digit expected next; cnt_q is 0 in IDLE so this also covers digit 0.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        cur_digit = pin_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign key_hit = (key_code == cur_digit);

  // Entry FSM with digit index, running match and registered output values.
  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    match_d   = match_q;
    cnt_d     = cnt_q;
    equal_d   = equal_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pin_load) begin
          pin_d = pin_data;
        end else if (key_valid) begin
          cnt_d   = CNT_W'(1);
          match_d = key_hit;
          equal_d = 1'b0;
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        err_d = pin_load;
        if (key_clear) begin
          cnt_d   = '0;
          match_d = 1'b1;
          state_d = ST_IDLE;
        end else if (key_valid) begin
          match_d = match_q & key_hit;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_REPORT;
          end
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          equal_d   = 1'b0;
          cnt_d     = '0;
          match_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_REPORT: begin
        done_d  = 1'b1;
        equal_d = match_q;
        err_d   = pin_load;
        cnt_d   = '0;
        match_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_COLLECT);
  end

  // State, PIN and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pin_q     <= DEFAULT_PIN;
      match_q   <= 1'b1;
      cnt_q     <= '0;
      equal_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      equal_q   <= equal_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign equal        = equal_q;
  assign entry_done   = done_q;
  assign entry_busy   = busy_q;
  assign timeout      = timeout_q;
  assign pin_load_err = err_q;
  assign digit_cnt    = cnt_q;

endmodule
